// File: rtl/reg_arb_pkg.sv
// Shared types and default sizing for the round-robin register-bank arbiter.
package reg_arb_pkg;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned DW_DEF    = 8;
    localparam int unsigned AW_DEF    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dff_async_vec.sv
// W-bit register with load enable and asynchronous active-low clear; one bank word.
module dff_async_vec #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter granting N_REQ requesters single-word access to a shared register bank.
module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned AW    = AW_DEF
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_we,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    ack,
    output logic [DW-1:0]       rdata,
    output logic                busy
);

    localparam int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    arb_state_t     state;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  win;
    logic [IW-1:0]  pick;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;
    logic           bank_we;
    logic [DW-1:0]  bank_q [DEPTH];

    // First requester at or above p, wrapping modulo N_REQ (safe for non-power-of-2 N_REQ).
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] w;
        logic          hit;
        int unsigned   idx;
        w   = p;
        hit = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(p) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!hit && r[IW'(idx)]) begin
                w   = IW'(idx);
                hit = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] w);
        return (w == IW'(N_REQ - 1)) ? '0 : w + IW'(1);
    endfunction

    always_comb begin
        pick      = rr_pick(req, ptr);
        sel_addr  = req_addr[win*AW +: AW];
        sel_wdata = req_wdata[win*DW +: DW];
        bank_we   = (state == GRANT) && req_we[win];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_bank
        dff_async_vec #(.W(DW)) u_word (
            .clk  (clk),
            .clrn (clrn),
            .en   (bank_we && (sel_addr == AW'(i))),
            .d    (sel_wdata),
            .q    (bank_q[i])
        );
    end

    // IDLE -> GRANT -> DONE; the winner's address, direction and data are taken during GRANT.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            ptr   <= '0;
            win   <= '0;
            gnt   <= '0;
            ack   <= '0;
            rdata <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (|req) begin
                        win   <= pick;
                        gnt   <= ONE << pick;
                        busy  <= 1'b1;
                        state <= GRANT;
                    end else begin
                        gnt <= '0;
                    end
                end
                GRANT: begin
                    gnt <= '0;
                    ack <= ONE << win;
                    if (!req_we[win]) begin
                        rdata <= bank_q[sel_addr];
                    end
                    state <= DONE;
                end
                DONE: begin
                    ack   <= '0;
                    ptr   <= next_ptr(win);
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
